// File: rtl/display_pkg.sv
// Shared FSM encodings, active-low 7-segment glyphs and the BCD-nibble decoder
// used by the count display driver and its double-dabble engine.
package display_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  // Cathode patterns, active low, ordered {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, WIDTH shifts per conversion,
// result presented on bcd_o during the single-cycle done_o pulse.
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             busy_o,
  output logic [15:0]      bcd_o,
  output logic             done_o
);

  localparam int unsigned SW = 16 + WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] sr_q, sr_d, sr_adj;
  logic [CW-1:0] cnt_q, cnt_d;

  // Add-3 correction on every BCD nibble that would overflow past 9 after the shift
  always_comb begin
    sr_adj = sr_q;
    for (int i = 0; i < 4; i++) begin
      if (sr_q[WIDTH + 4*i +: 4] >= 4'd5) begin
        sr_adj[WIDTH + 4*i +: 4] = sr_q[WIDTH + 4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          sr_d    = {16'd0, value_i};
          cnt_d   = CW'(WIDTH - 1);
          state_d = StShift;
        end
      end
      StShift: begin
        sr_d = sr_adj << 1;
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o = (state_q != StIdle);
  assign done_o = (state_q == StDone);
  assign bcd_o  = sr_q[SW-1 -: 16];

endmodule

// File: rtl/count_display_driver.sv
// Binary count -> BCD -> 4-digit multiplexed active-low 7-segment display.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits (ones digit always shown).
module count_display_driver
  import display_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic [3:0]       anode,
  output logic [6:0]       seg
);

  localparam int unsigned RW = $clog2(REFRESH_DIV + 1);

  logic [WIDTH-1:0] shown_q, shown_d;
  logic [15:0]      digit_q, digit_d;
  logic [RW-1:0]    refresh_q, refresh_d;
  logic [1:0]       idx_q, idx_d;

  logic        conv_busy, conv_done, start;
  logic [15:0] conv_bcd;
  logic        wrap;

  // Launch only from an idle engine; changes seen while busy are picked up afterwards
  assign start = (value != shown_q) && !conv_busy;

  bin2bcd_seq #(
    .WIDTH (WIDTH)
  ) u_bin2bcd (
    .clk     (clk),
    .reset   (reset),
    .start_i (start),
    .value_i (value),
    .busy_o  (conv_busy),
    .bcd_o   (conv_bcd),
    .done_o  (conv_done)
  );

  assign wrap = (refresh_q == RW'(REFRESH_DIV - 1));

  always_comb begin
    shown_d   = start ? value : shown_q;
    digit_d   = conv_done ? conv_bcd : digit_q;
    refresh_d = wrap ? '0 : refresh_q + 1'b1;
    idx_d     = wrap ? idx_q + 2'd1 : idx_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shown_q   <= '0;
      digit_q   <= '0;
      refresh_q <= '0;
      idx_q     <= '0;
    end else begin
      shown_q   <= shown_d;
      digit_q   <= digit_d;
      refresh_q <= refresh_d;
      idx_q     <= idx_d;
    end
  end

  // Display path reads only the committed digit registers, never the engine
  always_comb begin
    anode = ~(4'b0001 << idx_q);
    seg   = seg_decode(digit_q[4*idx_q +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
    if ((idx_q != 2'd0) && ((digit_q >> (4*idx_q)) == 16'd0)) begin
      seg = SEG_BLANK;
    end
`else
`endif
  end

  assign busy = conv_busy;

endmodule

// File: tb/tb_count_display_driver.sv
// Directed + randomized bench for count_display_driver with an arithmetic display model.
module tb_count_display_driver;

  localparam int unsigned WIDTH       = 8;
  localparam int unsigned REFRESH_DIV = 4;

  localparam logic [6:0] SEG_TAB [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] value = '0;
  logic             busy;
  logic [3:0]       anode;
  logic [6:0]       seg;

  int total = 0;
  int bad   = 0;
  int k     = 0;  // clock edges since reset release

  always #5 clk = ~clk;

  count_display_driver #(
    .WIDTH       (WIDTH),
    .REFRESH_DIV (REFRESH_DIV)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .value (value),
    .busy  (busy),
    .anode (anode),
    .seg   (seg)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (!reset) k++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int v, input int slot);
    int p;
    p = 1;
    for (int j = 0; j < slot; j++) p = p * 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (slot > 0 && v < p) return 7'b1111111;
`endif
    return SEG_TAB[(v / p) % 10];
  endfunction

  // Walk one full refresh frame, checking the lit position and its glyph each cycle
  task automatic scan(input int v, input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    for (int i = 0; i < 4 * REFRESH_DIV; i++) begin
      int slot;
      logic [3:0] ea;
      slot = (k / REFRESH_DIV) % 4;
      ea   = ~(4'b0001 << slot);
      chk({tag, "_anode"}, 32'(anode), 32'(ea));
      chk({tag, "_seg"}, 32'(seg), 32'(exp_seg(v, slot)));
      tick(1);
    end
  endtask

  initial begin
    int v;
    int last;

    // 1: reset state and quiet release
    reset = 1'b1;
    value = '0;
    tick(3);
    chk("rst_anode", 32'(anode), 32'(4'b1110));
    chk("rst_seg", 32'(seg), 32'(7'b1000000));
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    k = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("idle_busy", 32'(busy), 32'd0);
    end
    scan(0, "zero");

    // 2/3: single conversion latency, then a full mux frame
    value = 8'd27;
    tick(1);
    chk("conv_busy_rise", 32'(busy), 32'd1);
    tick(8);
    chk("conv_busy_last", 32'(busy), 32'd1);
    tick(1);
    chk("conv_busy_fall", 32'(busy), 32'd0);
    scan(27, "v27");

    // 4: top of range
    value = 8'd255;
    tick(12);
    scan(255, "v255");

    // 5: changes faster than a conversion settle on the last value
    value = 8'd27;
    tick(3);
    value = 8'd26;
    tick(3);
    value = 8'd25;
    tick(40);
    scan(25, "burst");

    // 6: reset in the middle of a conversion
    value = 8'd200;
    tick(1);
    chk("mid_busy", 32'(busy), 32'd1);
    tick(4);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_anode", 32'(anode), 32'(4'b1110));
    chk("abort_seg", 32'(seg), 32'(7'b1000000));
    tick(2);
    reset = 1'b0;
    k = 0;
    tick(1);
    chk("relaunch_busy", 32'(busy), 32'd1);
    tick(9);
    chk("relaunch_done", 32'(busy), 32'd0);
    scan(200, "v200");

    // Random single values
    for (int n = 0; n < 8; n++) begin
      v = int'($urandom_range(0, 255));
      value = 8'(v);
      tick(12);
      scan(v, "rand");
    end

    // Random bursts of changes with short gaps
    for (int n = 0; n < 4; n++) begin
      last = 0;
      for (int m = 0; m < 5; m++) begin
        last = int'($urandom_range(0, 255));
        value = 8'(last);
        tick(int'($urandom_range(1, 6)));
      end
      tick(30);
      scan(last, "rburst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
